// File: rtl/fb_pkg.sv
// Shared constants, FSM state type, request record and clipping helpers
// for the rectangle-fill scheduler.
package fb_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int PIXEL_W = 8;
  localparam int ADDR_W  = 19;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;

  // Sized copies so comparisons and arithmetic stay width-matched.
  localparam logic [X_W-1:0]    H_RES_X = X_W'(H_RES);
  localparam logic [Y_W-1:0]    V_RES_Y = Y_W'(V_RES);
  localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_e;

  typedef struct packed {
    logic [X_W-1:0]     x0;
    logic [Y_W-1:0]     y0;
    logic [X_W-1:0]     w;
    logic [Y_W-1:0]     h;
    logic [PIXEL_W-1:0] color;
  } fill_req_t;

  // Width actually written: zero when the rectangle starts off-screen,
  // otherwise truncated at the right edge.
  function automatic logic [X_W-1:0] clip_w(input logic [X_W-1:0] x0,
                                            input logic [X_W-1:0] w);
    logic [X_W-1:0] room;
    room = H_RES_X - x0;
    if (x0 >= H_RES_X) return '0;
    return (w < room) ? w : room;
  endfunction

  // Height actually written, truncated at the bottom edge.
  function automatic logic [Y_W-1:0] clip_h(input logic [Y_W-1:0] y0,
                                            input logic [Y_W-1:0] h);
    logic [Y_W-1:0] room;
    room = V_RES_Y - y0;
    if (y0 >= V_RES_Y) return '0;
    return (h < room) ? h : room;
  endfunction

endpackage

// File: rtl/fb_fill_scheduler_if.sv
// Request and framebuffer-write bundle of the fill scheduler. The slave
// modport is the scheduler; master is the requester/framebuffer side.
interface fb_fill_scheduler_if;
  import fb_pkg::*;

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [2*X_W-1:0]     req_x0;
  logic [2*Y_W-1:0]     req_y0;
  logic [2*X_W-1:0]     req_w;
  logic [2*Y_W-1:0]     req_h;
  logic [2*PIXEL_W-1:0] req_color;
  logic [1:0]           done;
  logic                 busy;
  logic                 fb_valid;
  logic                 fb_ready;
  logic [ADDR_W-1:0]    fb_addr;
  logic [PIXEL_W-1:0]   fb_data;

  modport master (
    output req_valid, req_x0, req_y0, req_w, req_h, req_color, fb_ready,
    input  req_ready, done, busy, fb_valid, fb_addr, fb_data
  );

  modport slave (
    input  req_valid, req_x0, req_y0, req_w, req_h, req_color, fb_ready,
    output req_ready, done, busy, fb_valid, fb_addr, fb_data
  );

endinterface

// File: rtl/fb_rr_arbiter2.sv
// Two-way round-robin arbiter. When both requesters are valid the one that
// was not granted last wins; a lone requester always wins.
module fb_rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid_i,
  input  logic       en_i,
  output logic       grant_o,
  output logic [1:0] ready_o
);

  logic last_grant_q;
  logic last_grant_d;
  logic grant;

  // Pick the requester to serve this cycle.
  always_comb begin
    grant = valid_i[1];
    if (valid_i == 2'b11) grant = ~last_grant_q;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign ready_o[gi] = en_i & valid_i[gi] & (grant == 1'(gi));
  end

  assign grant_o      = grant;
  assign last_grant_d = (|ready_o) ? grant : last_grant_q;

  // Remember the last accepted requester; reset favours requester 0 first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= 1'b1;
    else          last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/fb_fill_scheduler.sv
// Rectangle-fill engine in front of the framebuffer write port: arbitrates
// two requesters, clips the rectangle to the screen and streams one pixel
// write per accepted cycle using linear addresses y*H_RES + x.
module fb_fill_scheduler
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  fb_fill_scheduler_if.slave fill_if
);

  state_e             state_q;
  fill_req_t          req_q;
  logic               grant_q;
  logic [X_W-1:0]     eff_w_q;
  logic [Y_W-1:0]     eff_h_q;
  logic [X_W-1:0]     col_q;
  logic [Y_W-1:0]     row_q;
  logic [ADDR_W-1:0]  row_base_q;
  logic               fb_valid_q;
  logic [ADDR_W-1:0]  fb_addr_q;
  logic [PIXEL_W-1:0] fb_data_q;
  logic [1:0]         done_q;

  fill_req_t          req_in [2];
  logic [X_W-1:0]     eff_w_d;
  logic [Y_W-1:0]     eff_h_d;
  logic [ADDR_W-1:0]  row_base_d;
  logic               arb_en;
  logic               arb_grant;
  logic [1:0]         arb_ready;
  logic               accept;
  logic               last_col;
  logic               last_row;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign req_in[gi] = {fill_if.req_x0[gi*X_W +: X_W],
                         fill_if.req_y0[gi*Y_W +: Y_W],
                         fill_if.req_w[gi*X_W +: X_W],
                         fill_if.req_h[gi*Y_W +: Y_W],
                         fill_if.req_color[gi*PIXEL_W +: PIXEL_W]};
  end

  // Ready is only offered while idle and out of reset.
  assign arb_en = (state_q == IDLE) && reset_n;

  fb_rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_i (fill_if.req_valid),
    .en_i    (arb_en),
    .grant_o (arb_grant),
    .ready_o (arb_ready)
  );

  assign accept = |arb_ready;

  // Clipped extents and first-row address, consumed in SETUP.
  assign eff_w_d    = clip_w(req_q.x0, req_q.w);
  assign eff_h_d    = clip_h(req_q.y0, req_q.h);
  assign row_base_d = ADDR_W'(req_q.y0) * H_RES_A + ADDR_W'(req_q.x0);

  assign last_col = (col_q == eff_w_q - X_W'(1));
  assign last_row = (row_q == eff_h_q - Y_W'(1));

  // Fill FSM: accept, clip, stream pixels row by row, then pulse done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      grant_q    <= 1'b0;
      eff_w_q    <= '0;
      eff_h_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      fb_valid_q <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      done_q     <= 2'b00;
    end else begin
      done_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_q   <= req_in[arb_grant];
            grant_q <= arb_grant;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          eff_w_q    <= eff_w_d;
          eff_h_q    <= eff_h_d;
          row_base_q <= row_base_d;
          col_q      <= '0;
          row_q      <= '0;
          if (eff_w_d == '0 || eff_h_d == '0) begin
            done_q[grant_q] <= 1'b1;
            state_q         <= DONE;
          end else begin
            fb_addr_q  <= row_base_d;
            fb_data_q  <= req_q.color;
            fb_valid_q <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (fb_valid_q && fill_if.fb_ready) begin
            if (!last_col) begin
              col_q     <= col_q + X_W'(1);
              fb_addr_q <= fb_addr_q + ADDR_W'(1);
            end else if (!last_row) begin
              col_q      <= '0;
              row_q      <= row_q + Y_W'(1);
              row_base_q <= row_base_q + H_RES_A;
              fb_addr_q  <= row_base_q + H_RES_A;
            end else begin
              fb_valid_q      <= 1'b0;
              done_q[grant_q] <= 1'b1;
              state_q         <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fill_if.req_ready = arb_ready;
  assign fill_if.done      = done_q;
  assign fill_if.busy      = (state_q != IDLE);
  assign fill_if.fb_valid  = fb_valid_q;
  assign fill_if.fb_addr   = fb_addr_q;
  assign fill_if.fb_data   = fb_data_q;

endmodule
